// File: rtl/video_frame_sched_if.sv
// rtl/video_frame_sched_if.sv - AXI4-Stream video link with master/slave modports
interface video_frame_sched_if #(
    parameter int DW = 24
);
    logic [DW-1:0] tdata;
    logic          tvalid;
    logic          tready;
    logic          tuser;
    logic          tlast;

    modport master (output tdata, output tvalid, output tuser, output tlast, input tready);
    modport slave  (input tdata, input tvalid, input tuser, input tlast, output tready);
endinterface

// File: rtl/video_frame_sched.sv
// rtl/video_frame_sched.sv - four-slot frame-buffer scheduler with geometry checking
module video_frame_sched #(
    parameter int H_PIX   = 640,
    parameter int V_LINES = 480
) (
    input  logic                       clk,
    input  logic                       rstn,
    input  logic [3:0]                 Mem_cont,
    video_frame_sched_if.slave         s_axis_video,
    video_frame_sched_if.master        m_axis_video,
    input  logic                       rd_req,
    output logic [1:0]                 wr_slot,
    output logic [1:0]                 rd_slot,
    output logic                       rd_slot_valid,
    output logic                       frame_drop,
    output logic                       frame_err,
    output logic [15:0]                frame_cnt
);
    localparam int XW = (H_PIX > 1) ? $clog2(H_PIX) : 1;
    localparam int YW = (V_LINES > 1) ? $clog2(V_LINES) : 1;
    localparam logic [XW-1:0] X_LAST = XW'(H_PIX - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(V_LINES - 1);

    typedef enum logic [1:0] {ST_IDLE, ST_ACTIVE, ST_DROP} state_t;
    typedef enum logic [1:0] {SL_FREE, SL_WRITING, SL_READY, SL_READING} slot_t;

    state_t        r_state;
    slot_t         r_slot [4];
    logic [XW-1:0] r_x;
    logic [YW-1:0] r_y;
    logic [1:0]    r_wr_slot;
    logic [1:0]    r_rd_slot;
    logic          r_rd_slot_valid;
    logic          r_frame_drop;
    logic          r_frame_err;
    logic [15:0]   r_frame_cnt;

    state_t        w_state_nxt;
    slot_t         w_slot_nxt [4];
    logic [XW-1:0] w_x_nxt;
    logic [YW-1:0] w_y_nxt;
    logic [XW-1:0] w_xc;
    logic [YW-1:0] w_yc;
    logic [1:0]    w_wr_nxt;
    logic [1:0]    w_rd_nxt;
    logic          w_rdv_nxt;
    logic          w_drop_nxt;
    logic          w_err_nxt;
    logic [15:0]   w_cnt_nxt;
    logic          w_in_frame;
    logic          w_rd_found;
    logic [1:0]    w_rd_idx;
    logic          w_grant_ok;
    logic [1:0]    w_grant;
    logic          w_tready;
    logic          w_m_tvalid;
    logic          w_beat;

    // Slot grant from registered states: lowest enabled FREE slot, else overwrite the READY frame
    always_comb begin
        w_grant_ok = 1'b0;
        w_grant    = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (Mem_cont[i] && (r_slot[i] == SL_FREE)) begin
                w_grant_ok = 1'b1;
                w_grant    = 2'(i);
            end
        end
        if (!w_grant_ok) begin
            for (int i = 0; i < 4; i++) begin
                if (r_slot[i] == SL_READY) begin
                    w_grant_ok = 1'b1;
                    w_grant    = 2'(i);
                end
            end
        end
    end

    // Zero-latency data path: a granted SOF or any in-frame beat passes through, all else is sunk
    always_comb begin
        if (s_axis_video.tuser) begin
            w_tready = w_grant_ok ? m_axis_video.tready : 1'b1;
        end else if (r_state == ST_ACTIVE) begin
            w_tready = m_axis_video.tready;
        end else begin
            w_tready = 1'b1;
        end
        w_m_tvalid = rstn & s_axis_video.tvalid &
                     (s_axis_video.tuser ? w_grant_ok : (r_state == ST_ACTIVE));
    end

    assign w_beat               = s_axis_video.tvalid & w_tready;
    assign s_axis_video.tready  = w_tready;
    assign m_axis_video.tdata   = s_axis_video.tdata;
    assign m_axis_video.tuser   = s_axis_video.tuser;
    assign m_axis_video.tlast   = s_axis_video.tlast;
    assign m_axis_video.tvalid  = w_m_tvalid;

    // Next control state: SOF/allocation, geometry tracking, commit, then reader hand-off
    always_comb begin
        w_state_nxt = r_state;
        for (int i = 0; i < 4; i++) begin
            w_slot_nxt[i] = r_slot[i];
        end
        w_x_nxt    = r_x;
        w_y_nxt    = r_y;
        w_wr_nxt   = r_wr_slot;
        w_rd_nxt   = r_rd_slot;
        w_rdv_nxt  = r_rd_slot_valid;
        w_drop_nxt = 1'b0;
        w_err_nxt  = 1'b0;
        w_cnt_nxt  = r_frame_cnt;
        w_in_frame = (r_state == ST_ACTIVE);
        w_xc       = r_x;
        w_yc       = r_y;
        w_rd_found = 1'b0;
        w_rd_idx   = 2'd0;

        if (w_beat) begin
            if (s_axis_video.tuser) begin
                // A SOF inside a frame aborts the frame being written
                if (r_state == ST_ACTIVE) begin
                    w_err_nxt              = 1'b1;
                    w_slot_nxt[r_wr_slot]  = SL_FREE;
                end
                if (w_grant_ok) begin
                    w_slot_nxt[w_grant] = SL_WRITING;
                    w_wr_nxt            = w_grant;
                    w_xc                = '0;
                    w_yc                = '0;
                    w_in_frame          = 1'b1;
                end else begin
                    w_drop_nxt  = 1'b1;
                    w_in_frame  = 1'b0;
                    w_state_nxt = ST_DROP;
                    w_x_nxt     = '0;
                    w_y_nxt     = '0;
                end
            end
            if (w_in_frame) begin
                if (s_axis_video.tlast ? (w_xc != X_LAST) : (w_xc == X_LAST)) begin
                    w_err_nxt            = 1'b1;
                    w_slot_nxt[w_wr_nxt] = SL_FREE;
                    w_state_nxt          = ST_DROP;
                    w_x_nxt              = '0;
                    w_y_nxt              = '0;
                end else if (s_axis_video.tlast && (w_yc == Y_LAST)) begin
                    for (int i = 0; i < 4; i++) begin
                        if ((2'(i) != w_wr_nxt) && (w_slot_nxt[i] == SL_READY)) begin
                            w_slot_nxt[i] = SL_FREE;
                        end
                    end
                    w_slot_nxt[w_wr_nxt] = SL_READY;
                    w_cnt_nxt            = r_frame_cnt + 16'd1;
                    w_state_nxt          = ST_IDLE;
                    w_x_nxt              = '0;
                    w_y_nxt              = '0;
                end else if (s_axis_video.tlast) begin
                    w_x_nxt     = '0;
                    w_y_nxt     = w_yc + YW'(1);
                    w_state_nxt = ST_ACTIVE;
                end else begin
                    w_x_nxt     = w_xc + XW'(1);
                    w_y_nxt     = w_yc;
                    w_state_nxt = ST_ACTIVE;
                end
            end
        end

        // Reader sees the post-commit view, so a same-cycle commit is displayed immediately
        if (rd_req) begin
            for (int i = 0; i < 4; i++) begin
                if (w_slot_nxt[i] == SL_READY) begin
                    w_rd_found = 1'b1;
                    w_rd_idx   = 2'(i);
                end
            end
            if (w_rd_found) begin
                for (int i = 0; i < 4; i++) begin
                    if (w_slot_nxt[i] == SL_READING) begin
                        w_slot_nxt[i] = SL_FREE;
                    end
                end
                w_slot_nxt[w_rd_idx] = SL_READING;
                w_rd_nxt             = w_rd_idx;
                w_rdv_nxt            = 1'b1;
            end
        end
    end

    // Stream FSM, slot table and registered status outputs
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state         <= ST_IDLE;
            for (int i = 0; i < 4; i++) begin
                r_slot[i] <= SL_FREE;
            end
            r_x             <= '0;
            r_y             <= '0;
            r_wr_slot       <= 2'd0;
            r_rd_slot       <= 2'd0;
            r_rd_slot_valid <= 1'b0;
            r_frame_drop    <= 1'b0;
            r_frame_err     <= 1'b0;
            r_frame_cnt     <= 16'd0;
        end else begin
            r_state         <= w_state_nxt;
            for (int i = 0; i < 4; i++) begin
                r_slot[i] <= w_slot_nxt[i];
            end
            r_x             <= w_x_nxt;
            r_y             <= w_y_nxt;
            r_wr_slot       <= w_wr_nxt;
            r_rd_slot       <= w_rd_nxt;
            r_rd_slot_valid <= w_rdv_nxt;
            r_frame_drop    <= w_drop_nxt;
            r_frame_err     <= w_err_nxt;
            r_frame_cnt     <= w_cnt_nxt;
        end
    end

    assign wr_slot       = r_wr_slot;
    assign rd_slot       = r_rd_slot;
    assign rd_slot_valid = r_rd_slot_valid;
    assign frame_drop    = r_frame_drop;
    assign frame_err     = r_frame_err;
    assign frame_cnt     = r_frame_cnt;
endmodule

// File: tb/tb_video_frame_sched.sv
// tb/tb_video_frame_sched.sv - scoreboard bench for video_frame_sched on a reduced 8x4 frame
`timescale 1ns/1ps
module tb_video_frame_sched;
    localparam int H  = 8;
    localparam int V  = 4;
    localparam int NB = H * V;

    logic        clk = 1'b0;
    logic        rstn;
    logic [3:0]  mem_cont;
    logic        rd_req;
    logic [1:0]  wr_slot;
    logic [1:0]  rd_slot;
    logic        rd_slot_valid;
    logic        frame_drop;
    logic        frame_err;
    logic [15:0] frame_cnt;

    video_frame_sched_if s_if ();
    video_frame_sched_if m_if ();

    video_frame_sched #(.H_PIX(H), .V_LINES(V)) dut (
        .clk           (clk),
        .rstn          (rstn),
        .Mem_cont      (mem_cont),
        .s_axis_video  (s_if),
        .m_axis_video  (m_if),
        .rd_req        (rd_req),
        .wr_slot       (wr_slot),
        .rd_slot       (rd_slot),
        .rd_slot_valid (rd_slot_valid),
        .frame_drop    (frame_drop),
        .frame_err     (frame_err),
        .frame_cnt     (frame_cnt)
    );

    always #5 clk = ~clk;

    int          total  = 0;
    int          bad    = 0;
    int          n_drop = 0;
    int          n_err  = 0;
    int          bcnt   = 0;
    int          d0;
    int          e0;
    bit          burst    = 1'b0;
    bit          rand_rdy = 1'b0;
    logic [25:0] sb [$];
    logic [25:0] sb_exp;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    always @(posedge clk) begin
        #1;
        m_if.tready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    always @(negedge clk) begin
        if (frame_drop) n_drop++;
        if (frame_err)  n_err++;
        if (m_if.tvalid && m_if.tready) begin
            if (sb.size() == 0) begin
                chk("unexpected_beat", 32'(m_if.tvalid), 32'd0);
            end else begin
                sb_exp = sb.pop_front();
                chk("beat", 32'({m_if.tuser, m_if.tlast, m_if.tdata}), 32'(sb_exp));
            end
        end
    end

    task automatic send_beat(input logic [23:0] d, input logic u, input logic l, input bit fwd);
        int waitc;
        bit acc;
        if (burst) begin
            if (bcnt == 4) begin
                repeat (3) @(posedge clk);
                #1;
                bcnt = 0;
            end
            bcnt++;
        end
        s_if.tdata  = d;
        s_if.tuser  = u;
        s_if.tlast  = l;
        s_if.tvalid = 1'b1;
        if (fwd) sb.push_back({u, l, d});
        acc   = 1'b0;
        waitc = 0;
        while (!acc && waitc < 100) begin
            @(negedge clk);
            acc = s_if.tready;
            @(posedge clk);
            #1;
            waitc++;
        end
        s_if.tvalid = 1'b0;
        if (!acc) chk("tready_timeout", 32'(s_if.tready), 32'd1);
    endtask

    task automatic send_range(input logic [23:0] base, input bit fwd, input int k0, input int k1);
        for (int k = k0; k < k1; k++) begin
            send_beat(base + 24'(k), (k == 0), ((k % H) == H - 1), fwd);
        end
    endtask

    task automatic pulse_rd();
        rd_req = 1'b1;
        @(posedge clk);
        #1;
        rd_req = 1'b0;
    endtask

    task automatic do_reset(input bit hold_valid);
        rstn        = 1'b0;
        s_if.tvalid = hold_valid;
        s_if.tuser  = 1'b0;
        @(negedge clk);
        chk("rst_wr_slot", 32'(wr_slot), 32'd0);
        chk("rst_rd_slot", 32'(rd_slot), 32'd0);
        chk("rst_rd_valid", 32'(rd_slot_valid), 32'd0);
        chk("rst_drop", 32'(frame_drop), 32'd0);
        chk("rst_err", 32'(frame_err), 32'd0);
        chk("rst_cnt", 32'(frame_cnt), 32'd0);
        chk("rst_m_tvalid", 32'(m_if.tvalid), 32'd0);
        @(posedge clk);
        #1;
        s_if.tvalid = 1'b0;
        rstn        = 1'b1;
        bcnt        = 0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired observed=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        s_if.tvalid = 1'b0;
        s_if.tdata  = '0;
        s_if.tuser  = 1'b0;
        s_if.tlast  = 1'b0;
        rd_req      = 1'b0;
        mem_cont    = 4'hf;
        rstn        = 1'b0;
        @(posedge clk);
        #1;

        // three back-to-back frames in 4-on/3-off bursts, no reader
        do_reset(1'b0);
        burst = 1'b1;
        e0 = n_err;
        send_range(24'h100000, 1'b1, 0, NB);
        chk("t1_wr_f1", 32'(wr_slot), 32'd0);
        chk("t1_cnt_f1", 32'(frame_cnt), 32'd1);
        send_range(24'h200000, 1'b1, 0, NB);
        chk("t1_wr_f2", 32'(wr_slot), 32'd1);
        send_range(24'h300000, 1'b1, 0, NB);
        chk("t1_wr_f3", 32'(wr_slot), 32'd0);
        chk("t1_cnt_f3", 32'(frame_cnt), 32'd3);
        chk("t1_no_err", 32'(n_err - e0), 32'd0);
        burst = 1'b0;
        pulse_rd();
        chk("t1_rd_slot", 32'(rd_slot), 32'd0);
        chk("t1_rd_valid", 32'(rd_slot_valid), 32'd1);

        // reader hand-off with random memory backpressure
        do_reset(1'b0);
        rand_rdy = 1'b1;
        send_range(24'h110000, 1'b1, 0, NB);
        pulse_rd();
        chk("t2_rd_slot_a", 32'(rd_slot), 32'd0);
        chk("t2_rd_valid_a", 32'(rd_slot_valid), 32'd1);
        send_range(24'h120000, 1'b1, 0, NB);
        chk("t2_wr_f2", 32'(wr_slot), 32'd1);
        pulse_rd();
        chk("t2_rd_slot_b", 32'(rd_slot), 32'd1);
        pulse_rd();
        chk("t2_rd_repeat", 32'(rd_slot), 32'd1);
        send_range(24'h130000, 1'b1, 0, NB);
        chk("t2_wr_f3", 32'(wr_slot), 32'd0);
        rand_rdy = 1'b0;

        // only slot 0 enabled and held by the reader: whole frame dropped
        do_reset(1'b0);
        mem_cont = 4'b0001;
        send_range(24'h140000, 1'b1, 0, NB);
        pulse_rd();
        d0 = n_drop;
        e0 = n_err;
        send_range(24'h150000, 1'b0, 0, 1);
        chk("t3_drop_pulse", 32'(frame_drop), 32'd1);
        send_range(24'h150000, 1'b0, 1, NB);
        chk("t3_drop_count", 32'(n_drop - d0), 32'd1);
        chk("t3_no_err", 32'(n_err - e0), 32'd0);
        chk("t3_cnt", 32'(frame_cnt), 32'd1);
        mem_cont = 4'hf;
        send_range(24'h160000, 1'b1, 0, NB);
        chk("t3_wr_after", 32'(wr_slot), 32'd1);
        chk("t3_cnt_after", 32'(frame_cnt), 32'd2);

        // short line: tlast at x=5 on line 1
        do_reset(1'b0);
        e0 = n_err;
        send_range(24'h170000, 1'b1, 0, H + 5);
        send_beat(24'h170000 + 24'(H + 5), 1'b0, 1'b1, 1'b1);
        chk("t4_err_pulse", 32'(frame_err), 32'd1);
        @(posedge clk);
        #1;
        chk("t4_err_clear", 32'(frame_err), 32'd0);
        send_range(24'h170000, 1'b0, H + 6, NB);
        chk("t4_err_count", 32'(n_err - e0), 32'd1);
        chk("t4_cnt_none", 32'(frame_cnt), 32'd0);
        send_range(24'h180000, 1'b1, 0, NB);
        chk("t4_wr_clean", 32'(wr_slot), 32'd0);
        chk("t4_cnt_clean", 32'(frame_cnt), 32'd1);

        // SOF inside line 2 restarts into slot 1
        do_reset(1'b0);
        send_range(24'h190000, 1'b1, 0, 2 * H);
        send_range(24'h1a0000, 1'b1, 0, 1);
        chk("t5_err_pulse", 32'(frame_err), 32'd1);
        chk("t5_wr_new", 32'(wr_slot), 32'd1);
        send_range(24'h1a0000, 1'b1, 1, NB);
        chk("t5_cnt", 32'(frame_cnt), 32'd1);
        pulse_rd();
        chk("t5_rd_slot", 32'(rd_slot), 32'd1);
        send_range(24'h1b0000, 1'b1, 0, NB);
        chk("t5_wr_freed", 32'(wr_slot), 32'd0);
        chk("t5_cnt2", 32'(frame_cnt), 32'd2);

        // reset in the middle of a frame written to slot 2
        send_range(24'h1c0000, 1'b1, 0, 2 * H + 3);
        chk("t6_wr_before", 32'(wr_slot), 32'd2);
        s_if.tdata = 24'h1c0000 + 24'(2 * H + 3);
        do_reset(1'b1);
        send_range(24'h1d0000, 1'b1, 0, NB);
        chk("t6_wr_after", 32'(wr_slot), 32'd0);
        chk("t6_cnt_after", 32'(frame_cnt), 32'd1);
        chk("t6_rd_valid", 32'(rd_slot_valid), 32'd0);

        repeat (3) @(posedge clk);
        #1;
        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
